rsa_mmm: RTL and testbench

- Bit-serial radix-2 Montgomery modular multiplier (MMM) datapath; sits directly downstream of the RSA control FSM.
- Consumes the FSM's clear_mmm, ld_a and ld_r strobes. Produces P = A*B*2^-WIDTH mod M.
- Operand muxing (sel1/sel2) and result locking (lock1/lock2) are outside this block; A, B and M arrive already selected.
- One bit of A is consumed per enabled cycle: WIDTH iteration cycles, then one result-capture cycle.

---
 rtl/rsa_mmm.sv | 106 ++++++++++
 tb/tb_rsa_mmm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_mmm.sv
// rsa_mmm -- bit-serial radix-2 Montgomery modular multiplier datapath.
//
// Computes P = A * B * 2^-WIDTH mod M, one bit of A per enabled cycle.
// The RSA control FSM issues ld_a (PRE), WIDTH step cycles, then ld_r (POST).
//
// Ports:
//   clk      rising-edge system clock
//   rstb     asynchronous active-low reset
//   ena      clock enable; 0 freezes all state and ignores every strobe
//   clear    active-low synchronous clear of the working state (P holds)
//   ld_a     load A into the shift register, zero acc, restart the count
//   ld_r     capture the reduced accumulator into P
//   A        multiplier, consumed LSB first
//   B        multiplicand (< M), sampled on every iteration cycle
//   M        odd modulus, sampled on every iteration cycle and on ld_r
//   P        registered result
//   done     WIDTH iterations completed since the last ld_a
//   r_valid  P holds a captured result (set by ld_r, cleared by ld_a/clear)

module rsa_mmm #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             clear,
   input  logic             ld_a,
   input  logic             ld_r,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] M,
   output logic [WIDTH-1:0] P,
   output logic             done,
   output logic             r_valid
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   // acc stays below 2M, so it needs one bit more than the modulus
   logic signed [WIDTH:0] acc_dummy_unused;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] a_sr;
   logic [CW-1:0]    cnt;

   logic [WIDTH+1:0] t_sum;
   logic [WIDTH+1:0] u_sum;
   logic [WIDTH:0]   acc_nxt;

   // Final conditional subtraction: acc < 2M, so one subtraction suffices
   function automatic logic [WIDTH-1:0] reduce(input logic [WIDTH:0]   x,
                                               input logic [WIDTH-1:0] m);
      logic [WIDTH:0] diff;
      diff = x - {1'b0, m};
      if (x >= {1'b0, m}) begin
         return diff[WIDTH-1:0];
      end
      return x[WIDTH-1:0];
   endfunction

   assign acc_dummy_unused = '0;

   // One radix-2 Montgomery step: add B if the current A bit is set, then
   // add M when the sum is odd so the halving is exact.
   always_comb begin
      t_sum   = {1'b0, acc} + (a_sr[0] ? {2'b00, B} : '0);
      u_sum   = t_sum + (t_sum[0] ? {2'b00, M} : '0);
      acc_nxt = u_sum[WIDTH+1:1];
   end

   assign done = (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         acc     <= '0;
         a_sr    <= '0;
         cnt     <= '0;
         P       <= '0;
         r_valid <= 1'b0;
      end else if (ena) begin
         if (!clear) begin
            acc     <= '0;
            a_sr    <= '0;
            cnt     <= '0;
            r_valid <= 1'b0;
         end else begin
            // Capture uses the pre-edge acc; a same-cycle ld_a overrides r_valid
            if (ld_r) begin
               P       <= reduce(acc, M);
               r_valid <= 1'b1;
            end
            if (ld_a) begin
               a_sr    <= A;
               acc     <= '0;
               cnt     <= '0;
               r_valid <= 1'b0;
            end else if (cnt < CNT_MAX) begin
               acc  <= acc_nxt;
               a_sr <= a_sr >> 1;
               cnt  <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_rsa_mmm.sv
// tb_rsa_mmm -- directed testbench for rsa_mmm (WIDTH=8).
//
// Walks the FSM-style sequence ld_a -> 8 steps -> ld_r for a set of
// hand-computed vectors with M=239 (R=256, R mod M=17, R^-1 mod M=225),
// then exercises enable, clear, reset and strobe-overlap behaviour, and
// finishes with random odd-modulus vectors against a brute-force model.

module tb_rsa_mmm;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rstb;
   logic             ena;
   logic             clear;
   logic             ld_a;
   logic             ld_r;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] M;
   logic [WIDTH-1:0] P;
   logic             done;
   logic             r_valid;

   int checks = 0;
   int errors = 0;

   rsa_mmm #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rstb    (rstb),
      .ena     (ena),
      .clear   (clear),
      .ld_a    (ld_a),
      .ld_r    (ld_r),
      .A       (A),
      .B       (B),
      .M       (M),
      .P       (P),
      .done    (done),
      .r_valid (r_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample point is 1 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [WIDTH-1:0] a);
      A    = a;
      ld_a = 1'b1;
      tick();
      ld_a = 1'b0;
   endtask

   task automatic capture();
      ld_r = 1'b1;
      tick();
      ld_r = 1'b0;
   endtask

   task automatic mmm(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] m);
      B = b;
      M = m;
      load(a);
      repeat (WIDTH) tick();
      capture();
   endtask

   // Reference: the unique p < m with p * 2^WIDTH == a*b (mod m)
   function automatic int mont_ref(input int a, input int b, input int m);
      int target;
      target = (a * b) % m;
      for (int p = 0; p < m; p++) begin
         if (((p * 256) % m) == target) return p;
      end
      return -1;
   endfunction

   initial begin
      rstb  = 1'b0;
      ena   = 1'b1;
      clear = 1'b1;
      ld_a  = 1'b0;
      ld_r  = 1'b0;
      A     = '0;
      B     = '0;
      M     = 8'd239;
      tick();
      tick();
      check("reset_P", P, 0);
      check("reset_done", done, 0);
      check("reset_rvalid", r_valid, 0);
      rstb = 1'b1;
      tick();
      check("idle_done_after_reset", done, 0);

      // 5 * (R^2 mod M) -> 5*R mod 239 = 85; watch done timing
      B = 8'd50;
      M = 8'd239;
      load(8'd5);
      check("load_done_low", done, 0);
      check("load_rvalid_low", r_valid, 0);
      repeat (7) tick();
      check("done_low_after_7", done, 0);
      tick();
      check("done_high_after_8", done, 1);
      capture();
      check("p_5x50", P, 85);
      check("rvalid_after_ldr", r_valid, 1);

      mmm(8'd5, 8'd7, 8'd239);
      check("p_5x7", P, 227);
      mmm(8'd1, 8'd1, 8'd239);
      check("p_1x1", P, 225);
      mmm(8'd238, 8'd238, 8'd239);
      check("p_238x238", P, 225);
      mmm(8'd0, 8'd100, 8'd239);
      check("p_0x100", P, 0);

      // Extra idle cycles after done must not disturb acc
      mmm(8'd5, 8'd50, 8'd239);
      check("p_before_extra", P, 85);
      repeat (10) tick();
      check("done_holds_extra", done, 1);
      capture();
      check("p_after_extra", P, 85);

      // Enable freeze mid-iteration; ld_r while disabled is ignored
      mmm(8'd5, 8'd7, 8'd239);
      check("p_pre_freeze", P, 227);
      B = 8'd50;
      load(8'd5);
      repeat (4) tick();
      ena  = 1'b0;
      ld_r = 1'b1;
      repeat (3) tick();
      ld_r = 1'b0;
      check("freeze_rvalid", r_valid, 0);
      check("freeze_P", P, 227);
      ena = 1'b1;
      repeat (3) tick();
      check("freeze_done_low", done, 0);
      tick();
      check("freeze_done_high", done, 1);
      capture();
      check("freeze_p", P, 85);

      // Synchronous clear mid-iteration; strobes ignored while clear=0
      load(8'd5);
      repeat (4) tick();
      clear = 1'b0;
      ld_a  = 1'b1;
      ld_r  = 1'b1;
      A     = 8'd9;
      tick();
      ld_a  = 1'b0;
      ld_r  = 1'b0;
      clear = 1'b1;
      check("clear_done", done, 0);
      check("clear_rvalid", r_valid, 0);
      check("clear_P", P, 85);
      // Count restarts from zero after clear
      repeat (7) tick();
      check("clear_done_low_7", done, 0);
      tick();
      check("clear_done_high_8", done, 1);

      // Asynchronous reset mid-iteration
      load(8'd5);
      repeat (4) tick();
      rstb = 1'b0;
      #1;
      check("async_rst_P", P, 0);
      check("async_rst_done", done, 0);
      check("async_rst_rvalid", r_valid, 0);
      tick();
      rstb = 1'b1;
      tick();

      // Simultaneous ld_a + ld_r: old acc captured, iteration restarts
      B = 8'd1;
      load(8'd1);
      repeat (8) tick();
      A    = 8'd5;
      B    = 8'd50;
      ld_a = 1'b1;
      ld_r = 1'b1;
      tick();
      ld_a = 1'b0;
      ld_r = 1'b0;
      check("both_P", P, 225);
      check("both_rvalid", r_valid, 0);
      check("both_done", done, 0);
      repeat (8) tick();
      capture();
      check("both_followup_P", P, 85);

      // Random odd moduli with operands below M
      for (int i = 0; i < 1000; i++) begin
         int m;
         int a;
         int b;
         m = 2 * $urandom_range(1, 127) + 1;
         a = $urandom_range(0, m - 1);
         b = $urandom_range(0, m - 1);
         mmm(WIDTH'(a), WIDTH'(b), WIDTH'(m));
         check($sformatf("rand_%0d_a%0d_b%0d_m%0d", i, a, b, m), P, mont_ref(a, b, m));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
